// File: rtl/skew_feed_pkg.sv
// Shared types and helpers for the skewed fifo-bank feed controller.
//   feed_state_t : controller FSM states
//   feed_cycles  : number of FEED cycles for a given array dimension
//   in_window    : whether fifo i is inside the diagonal drain window at feed cycle t
package skew_feed_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFeed,
        StDone
    } feed_state_t;

    // Fifo DIM-1 starts DIM-1 cycles late and then drains DIM words.
    function automatic int unsigned feed_cycles(input int unsigned dim);
        return 2 * dim - 1;
    endfunction

    function automatic logic in_window(input int unsigned t, input int unsigned i,
                                       input int unsigned dim);
        return (t >= i) && (t < i + dim);
    endfunction

endpackage

// File: rtl/skew_feed_ctrl_skew_window.sv
// Diagonal drain window: mask bit i is set while fifo i is draining at feed cycle feed_cnt.
// Ports:
//   feed_cnt  in   FCW   current feed cycle
//   mask      out  DIM   per-fifo window mask
module skew_window
    import skew_feed_pkg::*;
#(
    parameter int unsigned DIM = 8,
    parameter int unsigned FCW = $clog2(2 * DIM)
) (
    input  logic [FCW-1:0] feed_cnt,
    output logic [DIM-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            mask[i] = in_window(32'(feed_cnt), i, DIM);
        end
    end

endmodule

// File: rtl/skew_feed_ctrl.sv
// Load-then-skewed-drain controller for a bank of DIM delay fifos feeding a systolic array.
// Loads DIM host rows in parallel over a valid/ready handshake, then drains fifo i
// starting i cycles after fifo 0 and flags which fifo heads are valid array operands.
// Optional build macro SKEW_FEED_PERF_EN adds perf_stall_cnt.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           single-cycle request (honoured only when idle)
//   in_valid/ready  host row handshake; in_data element i -> fifo i
//   fifo_en/fifo_d  per-fifo shift enable and data in
//   arr_valid       per-fifo head valid for the array this cycle
//   busy, done      not idle; one-cycle end-of-feed pulse
//   perf_stall_cnt  (SKEW_FEED_PERF_EN) LOAD cycles without in_valid, saturating
module skew_feed_ctrl
    import skew_feed_pkg::*;
#(
    parameter int unsigned DIM  = 8,
    parameter int unsigned BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIM*BITS-1:0] in_data,
    output logic [DIM-1:0]      fifo_en,
    output logic [DIM*BITS-1:0] fifo_d,
    output logic [DIM-1:0]      arr_valid,
    output logic                busy,
    output logic                done
`ifdef SKEW_FEED_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int unsigned LCW      = $clog2(DIM + 1);
    localparam int unsigned FCW      = $clog2(2 * DIM);
    localparam int unsigned FeedLast = feed_cycles(DIM) - 1;

    feed_state_t    state_q, state_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic [FCW-1:0] feed_cnt_q, feed_cnt_d;
    logic [DIM-1:0] window;

    skew_window #(
        .DIM (DIM),
        .FCW (FCW)
    ) u_window (
        .feed_cnt (feed_cnt_q),
        .mask     (window)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            feed_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            feed_cnt_q <= feed_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        feed_cnt_d = feed_cnt_q;
        in_ready   = 1'b0;
        fifo_en    = '0;
        fifo_d     = '0;
        arr_valid  = '0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Same-cycle write into every fifo; no output register stage.
                    fifo_en    = '1;
                    fifo_d     = in_data;
                    load_cnt_d = load_cnt_q + LCW'(1);
                    if (load_cnt_q == LCW'(DIM - 1)) begin
                        state_d    = StFeed;
                        feed_cnt_d = '0;
                    end
                end
            end
            StFeed: begin
                // Zeros are shifted in while the diagonal window drains each fifo.
                fifo_en    = window;
                arr_valid  = window;
                feed_cnt_d = feed_cnt_q + FCW'(1);
                if (feed_cnt_q == FCW'(FeedLast)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);

`ifdef SKEW_FEED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state_q == StIdle && start) begin
            perf_q <= '0;
        end else if (state_q == StLoad && !in_valid && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_skew_feed_ctrl.sv
module tb_skew_feed_ctrl;

    localparam int unsigned DIM  = 4;
    localparam int unsigned BITS = 8;
    localparam int unsigned NFEED = 2 * DIM - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [DIM*BITS-1:0] in_data;
    logic [DIM-1:0]      fifo_en;
    logic [DIM*BITS-1:0] fifo_d;
    logic [DIM-1:0]      arr_valid;
    logic                busy;
    logic                done;
`ifdef SKEW_FEED_PERF_EN
    logic [31:0]         perf_stall_cnt;
`endif

    skew_feed_ctrl #(
        .DIM  (DIM),
        .BITS (BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .fifo_en   (fifo_en),
        .fifo_d    (fifo_d),
        .arr_valid (arr_valid),
        .busy      (busy),
        .done      (done)
`ifdef SKEW_FEED_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference fifo bank: DIM-deep shift registers, head is the oldest stage.
    logic [BITS-1:0] sr [DIM][DIM];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++)
                for (int k = 0; k < DIM; k++) sr[i][k] <= '0;
        end else begin
            for (int i = 0; i < DIM; i++) begin
                if (fifo_en[i]) begin
                    for (int k = DIM - 1; k > 0; k--) sr[i][k] <= sr[i][k-1];
                    sr[i][0] <= fifo_d[i*BITS +: BITS];
                end
            end
        end
    end

    typedef struct {
        int unsigned    t;
        logic [DIM-1:0] en;
        logic [DIM-1:0] av;
    } feed_vec_t;

    feed_vec_t       tbl [NFEED];
    logic [BITS-1:0] sb [DIM][$];
    logic [31:0]     rows [DIM];
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_fifo_en"}, 64'(fifo_en), 64'd0);
        chk({tag, "_fifo_d"}, 64'(fifo_d), 64'd0);
        chk({tag, "_arr_valid"}, 64'(arr_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // One start/load/feed/done operation. Entered and left just after a rising edge.
    // gap_len: in_valid low cycles after the 2nd accepted row. noise: start and
    // in_valid toggled where they must be ignored. abort_t: feed cycle to reset at (-1 none).
    task automatic do_op(input int gap_len, input bit noise, input int abort_t);
        int k;
        int gap_left;
        int budget;
        logic [BITS-1:0] exp_head;

        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        @(posedge clk); #1;

        k        = 0;
        gap_left = gap_len;
        budget   = 0;
        while (k < DIM && budget < 4 * DIM + gap_len) begin
            budget++;
            start = noise;
            if (k == 2 && gap_left > 0) begin
                gap_left--;
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = rows[k];
            end
            @(negedge clk);
            chk("load_ready", 64'(in_ready), 64'd1);
            chk("load_busy", 64'(busy), 64'd1);
            if (in_valid) begin
                chk("load_fifo_en", 64'(fifo_en), 64'hF);
                chk("load_fifo_d", 64'(fifo_d), 64'(rows[k]));
                for (int i = 0; i < DIM; i++) sb[i].push_back(rows[k][i*BITS +: BITS]);
                k++;
            end else begin
                chk("gap_fifo_en", 64'(fifo_en), 64'd0);
            end
            @(posedge clk); #1;
        end
        if (k < DIM) chk("load_timeout", 64'(k), 64'(DIM));

        for (int t = 0; t < NFEED; t++) begin
            start    = noise;
            in_valid = noise;
            in_data  = $urandom;
            if (t == abort_t) begin
                start    = 1'b0;
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                chk_quiet("abort");
                for (int i = 0; i < DIM; i++) sb[i].delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            chk("feed_arr_valid", 64'(arr_valid), 64'(tbl[t].av));
            chk("feed_fifo_en", 64'(fifo_en), 64'(tbl[t].en));
            chk("feed_fifo_d", 64'(fifo_d), 64'd0);
            chk("feed_ready", 64'(in_ready), 64'd0);
            chk("feed_busy", 64'(busy), 64'd1);
            chk("feed_done", 64'(done), 64'd0);
            for (int i = 0; i < DIM; i++) begin
                if (tbl[t].av[i]) begin
                    if (sb[i].size() == 0) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        exp_head = sb[i].pop_front();
                        chk("fifo_head", 64'(sr[i][DIM-1]), 64'(exp_head));
                    end
                end
            end
            @(posedge clk); #1;
        end

        start    = noise;
        in_valid = noise;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_arr_valid", 64'(arr_valid), 64'd0);
        for (int i = 0; i < DIM; i++) chk("sb_drained", 64'(sb[i].size()), 64'd0);
`ifdef SKEW_FEED_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'(gap_len));
`endif
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 4'h1, 4'h1};
        tbl[1] = '{1, 4'h3, 4'h3};
        tbl[2] = '{2, 4'h7, 4'h7};
        tbl[3] = '{3, 4'hF, 4'hF};
        tbl[4] = '{4, 4'hE, 4'hE};
        tbl[5] = '{5, 4'hC, 4'hC};
        tbl[6] = '{6, 4'h8, 4'h8};

        rst_n    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        chk_quiet("rst");
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("rst_held");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("post_rst");
        end
        @(posedge clk); #1;

        rows = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        do_op(0, 1'b0, -1);
        do_op(3, 1'b0, -1);

        rows = '{32'hA1B2C3D4, 32'h5566E7F8, 32'h99AABBCC, 32'h0F1E2D3C};
        do_op(0, 1'b1, -1);

        do_op(0, 1'b0, 2);
        @(negedge clk);
        chk_quiet("after_abort");
        @(posedge clk); #1;
        rows = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        do_op(1, 1'b0, -1);

        rows = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        do_op(0, 1'b0, -1);
        rows = '{32'hF0E0D0C0, 32'hB0A09080, 32'h70605040, 32'h30201000};
        do_op(2, 1'b0, -1);

        @(negedge clk);
        chk_quiet("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
